// File: rtl/rx_uart.sv
// UART receiver. Samples i_rx with a 16x oversampling tick and delivers framed bytes
// with done/frame-error pulses.
module rx_uart #(
    parameter int unsigned NB_DATA  = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned NB_STATE = 3
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_error
);

    localparam int unsigned NB_TICK = 4;
    localparam int unsigned NB_BIT  = $clog2(NB_DATA);

    typedef enum logic [NB_STATE-1:0] {
        IDLE      = NB_STATE'(0),
        START     = NB_STATE'(1),
        DATA      = NB_STATE'(2),
        STOP      = NB_STATE'(3),
        WAIT_HIGH = NB_STATE'(4)
    } state_e;

    state_e               state_q, state_d;
    logic [NB_TICK-1:0]   tick_q, tick_d;
    logic [NB_BIT-1:0]    bit_q, bit_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic [NB_DATA-1:0]   data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                // Mid start bit: a high line here is a glitch, not a frame.
                if (i_s_tick) begin
                    if (tick_q == NB_TICK'(7)) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (tick_q == NB_TICK'(15)) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[NB_DATA-1:1]};
                        if (bit_q == NB_BIT'(NB_DATA - 1)) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + NB_BIT'(1);
                        end
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (tick_q == NB_TICK'(SB_TICK - 1)) begin
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + NB_TICK'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                // Break condition: stay silent until the line returns high.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_frame_error  = ferr_q;

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart: a bench-side serial transmitter at 64 clocks per bit,
// pulse counters and a vector table of frames with hand-computed expectations.
module tb_rx_uart;

    logic       i_clock;
    logic       i_reset;
    logic       i_s_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_rx_done_tick;
    logic       o_frame_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int ferr_cnt     = 0;
    int both_high    = 0;
    int done_prev    = 0;
    int ferr_prev    = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    rx_uart #(.NB_DATA(8), .SB_TICK(16), .NB_STATE(3)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_s_tick       (i_s_tick),
        .i_rx           (i_rx),
        .o_data         (o_data),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_error  (o_frame_error)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    // Oversampling tick: one clock high in every four.
    initial begin
        i_s_tick = 1'b0;
        forever begin
            for (int k = 0; k < 4; k++) begin
                @(negedge i_clock);
                i_s_tick = (k == 3);
            end
        end
    end

    always @(negedge i_clock) begin
        if (o_rx_done_tick) done_cnt++;
        if (o_frame_error)  ferr_cnt++;
        if (o_rx_done_tick && o_frame_error) both_high++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_bits(input int n);
        i_rx = 1'b1;
        repeat (64 * n) @(negedge i_clock);
    endtask

    // Reset is raised mid-bit rst_bit and held to the end of the frame (rst_bit<0: none).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
        i_rx = 1'b0;
        repeat (64) @(negedge i_clock);
        for (int b = 0; b < 8; b++) begin
            i_rx = d[b];
            for (int c = 0; c < 64; c++) begin
                if (b == rst_bit && c == 32) i_reset = 1'b1;
                @(negedge i_clock);
            end
        end
        i_rx = stop;
        repeat (64) @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    task automatic check_deltas(input string name, input int exp_done, input int exp_ferr,
                                input logic [7:0] exp_data);
        check({name, "_done"}, done_cnt - done_prev, exp_done);
        check({name, "_ferr"}, ferr_cnt - ferr_prev, exp_ferr);
        check({name, "_data"}, int'(o_data), int'(exp_data));
        done_prev = done_cnt;
        ferr_prev = ferr_cnt;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h3C, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_data: 8'h3C};
        vecs[2] = '{data: 8'h96, stop: 1'b0, exp_done: 0, exp_ferr: 1, exp_data: 8'h3C};
        vecs[3] = '{data: 8'h80, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_data: 8'h80};
        vecs[4] = '{data: 8'h7E, stop: 1'b1, exp_done: 1, exp_ferr: 0, exp_data: 8'h7E};

        i_reset = 1'b1;
        i_rx    = 1'b1;
        repeat (5) @(negedge i_clock);
        check("reset_data", int'(o_data), 0);
        check("reset_done", int'(o_rx_done_tick), 0);
        check("reset_ferr", int'(o_frame_error), 0);
        i_reset = 1'b0;
        idle_bits(1);

        send_frame(8'h55, 1'b1, -1);
        idle_bits(1);
        check_deltas("frame55", 1, 0, 8'h55);

        // Short low pulse rejected at mid start bit.
        i_rx = 1'b0;
        repeat (16) @(negedge i_clock);
        idle_bits(2);
        check_deltas("glitch", 0, 0, 8'h55);

        // Stop bit low followed by a 40-tick break.
        send_frame(8'h01, 1'b0, -1);
        i_rx = 1'b0;
        repeat (160) @(negedge i_clock);
        check_deltas("break", 0, 1, 8'h55);

        idle_bits(1);
        send_frame(8'h20, 1'b1, -1);
        idle_bits(1);
        check_deltas("after_break", 1, 0, 8'h20);

        send_frame(8'hA3, 1'b1, 3);
        check("midrst_data", int'(o_data), 0);
        check("midrst_done", int'(o_rx_done_tick), 0);
        check("midrst_ferr", int'(o_frame_error), 0);
        idle_bits(1);
        check_deltas("midrst_pulses", 0, 0, 8'h00);
        send_frame(8'hA3, 1'b1, -1);
        idle_bits(1);
        check_deltas("after_rst", 1, 0, 8'hA3);

        send_frame(8'h00, 1'b1, -1);
        check_deltas("b2b_first", 1, 0, 8'h00);
        send_frame(8'hFF, 1'b1, -1);
        check_deltas("b2b_second", 1, 0, 8'hFF);
        idle_bits(1);

        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, -1);
            idle_bits(1);
            check_deltas($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_ferr,
                         vecs[v].exp_data);
        end

        check("never_both_high", both_high, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
